// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder stage with a registered carry,
// consuming operands LSB first and delivering a WIDTH+1-bit sum after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_sum;
    logic             carry_next;
    logic             last_bit;

    // One-bit add stage fed by the operand LSBs and the carry loop.
    assign bit_sum    = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    // Each new bit enters at the MSB, so after WIDTH shifts bit i sits at position i.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_next = bit_sum;
        end else begin : g_res_many
            assign res_next = {bit_sum, res_sr[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)    state_next = RUN;
            RUN:  if (last_bit) state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        cnt    <= '0;
                        carry  <= 1'b0;
                        sum    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    res_sr <= res_next;
                    cnt    <= cnt + 1'b1;
                    // Final step publishes the accumulated bits and the carry-out together.
                    if (last_bit) begin
                        sum  <= {carry_next, res_next};
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and model-checked bench for serial_adder at WIDTH = 8, 1 and 16.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [8:0]  sum8;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        busy1, done1;
    logic [1:0]  sum1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [16:0] sum16;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int n_done8 = 0, n_done1 = 0, n_done16 = 0;
    int exp_done8 = 0, exp_done1 = 0, exp_done16 = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8));

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1));

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16));

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (done8  === 1'b1) n_done8++;
        if (done1  === 1'b1) n_done1++;
        if (done16 === 1'b1) n_done16++;
    end

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one add on the 8-bit instance and wait (bounded) for done.
    task automatic do_add8(input logic [7:0] a, input logic [7:0] b,
                           output logic [8:0] got, output int lat);
        a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_done8++;
        lat = 0;
        got = 'x;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (done8 === 1'b1) begin
                got = sum8;
                break;
            end
        end
    endtask

    task automatic do_add16(input logic [15:0] a, input logic [15:0] b,
                            output logic [16:0] got, output int lat);
        a16 = a; b16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        exp_done16++;
        lat = 0;
        got = 'x;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (done16 === 1'b1) begin
                got = sum16;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({busy8, done8, sum8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_w8: busy=%b done=%b sum=%h, want 0 0 000", busy8, done8, sum8);
        end
        n_vec++;
        if ({busy1, done1, sum1} !== 4'd0) begin
            n_err++;
            $display("FAIL reset_w1: busy=%b done=%b sum=%b, want 0 0 00", busy1, done1, sum1);
        end
        n_vec++;
        if ({busy16, done16, sum16} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_w16: busy=%b done=%b sum=%h, want 0 0 00000", busy16, done16, sum16);
        end
    endtask

    task automatic test_carry_chain();
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_done8++;
        n_vec++;
        if (busy8 !== 1'b1 || sum8 !== 9'h000) begin
            n_err++;
            $display("FAIL accept_w8: busy=%b sum=%h, want 1 000", busy8, sum8);
        end
        for (int i = 1; i < 8; i++) begin
            tick();
            n_vec++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_err++;
                $display("FAIL run_w8 cyc%0d: busy=%b done=%b, want 1 0", i, busy8, done8);
            end
        end
        tick();
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b1 || sum8 !== 9'h100) begin
            n_err++;
            $display("FAIL ff_plus_01: busy=%b done=%b sum=%h, want 0 1 100", busy8, done8, sum8);
        end
        tick();
        n_vec++;
        if (done8 !== 1'b0 || sum8 !== 9'h100) begin
            n_err++;
            $display("FAIL done_pulse_hold: done=%b sum=%h, want 0 100", done8, sum8);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        a8 = 8'h5A; b8 = 8'hA5; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_done8++;
        for (int i = 0; i < 7; i++) tick();
        tick();
        t1 = cycle;
        n_vec++;
        if (done8 !== 1'b1 || sum8 !== 9'h0FF) begin
            n_err++;
            $display("FAIL b2b_first: done=%b sum=%h, want 1 0FF", done8, sum8);
        end
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_done8++;
        n_vec++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || sum8 !== 9'h000) begin
            n_err++;
            $display("FAIL b2b_accept_in_done: done=%b busy=%b sum=%h, want 0 1 000", done8, busy8, sum8);
        end
        t2 = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 === 1'b1) begin
                t2 = cycle;
                break;
            end
        end
        n_vec++;
        if (sum8 !== 9'h1FE) begin
            n_err++;
            $display("FAIL b2b_second: sum=%h, want 1FE", sum8);
        end
        n_vec++;
        if (t2 - t1 !== 9) begin
            n_err++;
            $display("FAIL b2b_spacing: %0d cycles, want 9", t2 - t1);
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        logic [8:0] got = 'x;
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_done8++;
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 === 1'b1) begin
                dones++;
                got = sum8;
            end
        end
        n_vec++;
        if (got !== 9'h046) begin
            n_err++;
            $display("FAIL ignore_start_sum: sum=%h, want 046", got);
        end
        n_vec++;
        if (dones !== 1 || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_pulses: dones=%0d busy=%b, want 1 0", dones, busy8);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        logic [8:0] got;
        int lat;
        a8 = 8'hC3; b8 = 8'h3C; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 9'h000) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h, want 0 0 000", busy8, done8, sum8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: dones=%0d, want 0", dones);
        end
        do_add8(8'h01, 8'h01, got, lat);
        n_vec++;
        if (got !== 9'h002 || lat !== 8) begin
            n_err++;
            $display("FAIL after_reset_add: sum=%h lat=%0d, want 002 8", got, lat);
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp_tab [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1); b1 = 1'(i); start1 = 1'b1;
            tick();
            start1 = 1'b0;
            exp_done1++;
            n_vec++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL w1_accept %0d: busy=%b done=%b, want 1 0", i, busy1, done1);
            end
            tick();
            n_vec++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== exp_tab[i]) begin
                n_err++;
                $display("FAIL w1_sum %0d+%0d: done=%b busy=%b sum=%b, want 1 0 %b",
                         a1, b1, done1, busy1, sum1, exp_tab[i]);
            end
        end
    endtask

    task automatic test_model_compare();
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        logic [8:0]  got8;
        logic [16:0] got16;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            do_add8(ra8, rb8, got8, lat);
            n_vec++;
            if (got8 !== {1'b0, ra8} + {1'b0, rb8} || lat !== 8) begin
                n_err++;
                $display("FAIL model_w8 %h+%h: sum=%h lat=%0d, want %h 8",
                         ra8, rb8, got8, lat, {1'b0, ra8} + {1'b0, rb8});
            end
        end
        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            do_add16(ra16, rb16, got16, lat);
            n_vec++;
            if (got16 !== {1'b0, ra16} + {1'b0, rb16} || lat !== 16) begin
                n_err++;
                $display("FAIL model_w16 %h+%h: sum=%h lat=%0d, want %h 16",
                         ra16, rb16, got16, lat, {1'b0, ra16} + {1'b0, rb16});
            end
        end
    endtask

    task automatic test_done_accounting();
        tick();
        tick();
        n_vec++;
        if (n_done8 !== exp_done8 || n_done1 !== exp_done1 || n_done16 !== exp_done16) begin
            n_err++;
            $display("FAIL done_count: w8=%0d w1=%0d w16=%0d, want %0d %0d %0d",
                     n_done8, n_done1, n_done16, exp_done8, exp_done1, exp_done16);
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
        test_width1();
        test_model_compare();
        test_done_accounting();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
